// File: rtl/interpo_lut_engine.sv
// Piecewise-linear interpolator over a 32-entry signed table held in an external
// dual-port RAM. A 16-bit unsigned sample selects a table segment (upper ADDR_W
// bits) and a position within it (lower FRAC_W bits). The block reads both
// segment endpoints through the RAM read port and emits the rounded linear blend.
//
// Ports:
//   clk               system clock, shared with the RAM read port
//   reset             synchronous, active-high
//   in_valid_i        input sample valid
//   in_ready_o        block can accept a sample (only when idle)
//   in_data_i         unsigned sample: [15:11] table index, [10:0] fraction
//   out_valid_o       result valid, held until out_ready_i
//   out_ready_i       downstream accepts result
//   out_data_o        signed interpolated result
//   mem_address_o     RAM read address (registered inside the RAM)
//   mem_chipselect_o  RAM read enable
//   mem_write_o       RAM write enable, tied low
//   mem_readdata_i    RAM read data, one cycle after address; low SAMPLE_W bits used
module interpo_lut_engine #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned SAMPLE_W  = 16,
  parameter bit          WRAP_LAST = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [SAMPLE_W-1:0] in_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [SAMPLE_W-1:0] out_data_o,
  output logic [ADDR_W-1:0]   mem_address_o,
  output logic                mem_chipselect_o,
  output logic                mem_write_o,
  input  logic [31:0]         mem_readdata_i
);

  localparam int unsigned FRAC_W = SAMPLE_W - ADDR_W;
  // diff is SAMPLE_W+1 bits, zero-extended frac is FRAC_W+1 bits
  localparam int unsigned PROD_W = SAMPLE_W + FRAC_W + 2;
  localparam logic [PROD_W-1:0] RoundHalf =
    {{(PROD_W - FRAC_W){1'b0}}, 1'b1, {(FRAC_W - 1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StRd0, StRd1, StCalc, StOut} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [FRAC_W-1:0]   frac_q, frac_d;
  logic [SAMPLE_W-1:0] y0_q, y0_d;
  logic [SAMPLE_W-1:0] out_data_q, out_data_d;

  // Address of the upper segment endpoint; the last entry either clamps to
  // itself or wraps to entry 0 for periodic tables.
  logic [ADDR_W-1:0] idx_next;
  always_comb begin
    if (idx_q == {ADDR_W{1'b1}}) begin
      idx_next = WRAP_LAST ? '0 : idx_q;
    end else begin
      idx_next = idx_q + ADDR_W'(1);
    end
  end

  // Interpolation datapath, consumed in StCalc when y1 is on the read bus.
  logic signed [SAMPLE_W-1:0] y1_s;
  logic signed [SAMPLE_W:0]   diff;
  logic signed [FRAC_W:0]     frac_s;
  logic signed [PROD_W-1:0]   prod;
  logic signed [PROD_W-1:0]   prod_rnd;
  logic signed [PROD_W-1:0]   delta;
  logic [SAMPLE_W-1:0]        interp;

  assign y1_s     = mem_readdata_i[SAMPLE_W-1:0];
  assign diff     = {y1_s[SAMPLE_W-1], y1_s} - {y0_q[SAMPLE_W-1], y0_q};
  assign frac_s   = {1'b0, frac_q};
  assign prod     = diff * frac_s;
  assign prod_rnd = prod + $signed(RoundHalf);
  // Arithmetic shift floors, so with the +half bias ties round upward.
  assign delta    = prod_rnd >>> FRAC_W;
  // |delta| <= |diff|, so the sum stays between y0 and y1 and cannot overflow.
  assign interp   = y0_q + delta[SAMPLE_W-1:0];

  logic unused_bits;
  assign unused_bits = ^{mem_readdata_i[31:SAMPLE_W], delta[PROD_W-1:SAMPLE_W]};

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    frac_d           = frac_q;
    y0_d             = y0_q;
    out_data_d       = out_data_q;
    in_ready_o       = 1'b0;
    out_valid_o      = 1'b0;
    mem_chipselect_o = 1'b0;
    mem_address_o    = '0;
    unique case (state_q)
      StIdle: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          idx_d   = in_data_i[SAMPLE_W-1:FRAC_W];
          frac_d  = in_data_i[FRAC_W-1:0];
          state_d = StRd0;
        end
      end
      StRd0: begin
        mem_chipselect_o = 1'b1;
        mem_address_o    = idx_q;
        state_d          = StRd1;
      end
      StRd1: begin
        mem_chipselect_o = 1'b1;
        mem_address_o    = idx_next;
        y0_d             = mem_readdata_i[SAMPLE_W-1:0];
        state_d          = StCalc;
      end
      StCalc: begin
        out_data_d = interp;
        state_d    = StOut;
      end
      StOut: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      frac_q     <= '0;
      y0_q       <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      frac_q     <= frac_d;
      y0_q       <= y0_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign mem_write_o = 1'b0;

endmodule

// File: tb/tb_interpo_lut_engine.sv
// Bench for interpo_lut_engine: two instances (clamped and wrapping last entry)
// share stimulus, each with its own RAM read-port model over a common table.
module tb_interpo_lut_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        in_ready0, out_valid0, cs0, we0;
  logic [15:0] out_data0;
  logic [4:0]  addr0;
  logic [31:0] rd0;
  logic        in_ready1, out_valid1, cs1, we1;
  logic [15:0] out_data1;
  logic [4:0]  addr1;
  logic [31:0] rd1;

  logic [31:0] tbl [32];
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  interpo_lut_engine #(.ADDR_W(5), .SAMPLE_W(16), .WRAP_LAST(1'b0)) u0 (
    .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(in_ready0),
    .in_data_i(in_data), .out_valid_o(out_valid0), .out_ready_i(out_ready),
    .out_data_o(out_data0), .mem_address_o(addr0), .mem_chipselect_o(cs0),
    .mem_write_o(we0), .mem_readdata_i(rd0)
  );

  interpo_lut_engine #(.ADDR_W(5), .SAMPLE_W(16), .WRAP_LAST(1'b1)) u1 (
    .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .in_data_i(in_data), .out_valid_o(out_valid1), .out_ready_i(out_ready),
    .out_data_o(out_data1), .mem_address_o(addr1), .mem_chipselect_o(cs1),
    .mem_write_o(we1), .mem_readdata_i(rd1)
  );

  // RAM port 2 model: registered address, data one cycle later.
  always @(posedge clk) begin
    if (cs0) rd0 <= tbl[addr0];
    if (cs1) rd1 <= tbl[addr1];
  end

  // Scoreboard: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (out_valid0 && out_ready) begin
      n_checks++;
      if (q0.size() == 0) $display("FAIL sb0_unexpected: got %0d, none expected", out_data0);
      else begin
        logic [15:0] e;
        e = q0.pop_front();
        if (out_data0 !== e) $display("FAIL sb0_data: got %h, want %h", out_data0, e);
        else n_pass++;
      end
    end
    if (out_valid1 && out_ready) begin
      n_checks++;
      if (q1.size() == 0) $display("FAIL sb1_unexpected: got %0d, none expected", out_data1);
      else begin
        logic [15:0] e;
        e = q1.pop_front();
        if (out_data1 !== e) $display("FAIL sb1_data: got %h, want %h", out_data1, e);
        else n_pass++;
      end
    end
  end

  // Presents a sample and returns just after the accepting edge (state RD0).
  task automatic send(input logic [15:0] d, input logic [15:0] e0, input logic [15:0] e1,
                      input bit push);
    bit ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready0 && in_ready1) ok = 1'b1;
    end
    n_checks++;
    if (!ok) $display("FAIL send_timeout: in_ready low for 20 cycles, want high");
    else n_pass++;
    if (push) begin
      q0.push_back(e0);
      q1.push_back(e1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (in_ready0 && in_ready1 && !out_valid0 && !out_valid1) ok = 1'b1;
    end
    n_checks++;
    if (!ok) $display("FAIL idle_timeout: not idle after 30 cycles, want idle");
    else n_pass++;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({in_ready0, out_valid0, cs0, we0, addr0, out_data0} !== {4'b1000, 5'd0, 16'd0})
      $display("FAIL reset0: rdy=%b vld=%b cs=%b we=%b addr=%0d data=%h, want 1 0 0 0 0 0000",
               in_ready0, out_valid0, cs0, we0, addr0, out_data0);
    else n_pass++;
    n_checks++;
    if ({in_ready1, out_valid1, cs1, we1, addr1, out_data1} !== {4'b1000, 5'd0, 16'd0})
      $display("FAIL reset1: rdy=%b vld=%b cs=%b we=%b addr=%0d data=%h, want 1 0 0 0 0 0000",
               in_ready1, out_valid1, cs1, we1, addr1, out_data1);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    send(16'h2C00, 16'd5500, 16'd5500, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({cs0, addr0, cs1, addr1} !== {1'b1, 5'd5, 1'b1, 5'd5})
      $display("FAIL basic_rd0: cs=%b/%b addr=%0d/%0d, want 1/1 5/5", cs0, cs1, addr0, addr1);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({cs0, addr0, cs1, addr1} !== {1'b1, 5'd6, 1'b1, 5'd6})
      $display("FAIL basic_rd1: cs=%b/%b addr=%0d/%0d, want 1/1 6/6", cs0, cs1, addr0, addr1);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({cs0, out_valid0, we0} !== 3'b000)
      $display("FAIL basic_calc: cs=%b vld=%b we=%b, want 0 0 0", cs0, out_valid0, we0);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({out_valid0, out_valid1, in_ready0} !== 3'b110)
      $display("FAIL basic_latency: vld=%b/%b rdy=%b, want 1/1 0", out_valid0, out_valid1,
               in_ready0);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_wrap();
    send(16'hFFFF, 16'd31000, 16'd15, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({addr0, addr1} !== {5'd31, 5'd31})
      $display("FAIL wrap_rd0: addr=%0d/%0d, want 31/31", addr0, addr1);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({addr0, addr1} !== {5'd31, 5'd0})
      $display("FAIL wrap_rd1: addr=%0d/%0d, want 31/0", addr0, addr1);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_extremes();
    tbl[2] = 32'hABCD_8000;
    tbl[3] = 32'hABCD_7FFF;
    send(16'h1000, 16'h8000, 16'h8000, 1'b1);
    wait_idle();
    send(16'h17FF, 16'h7FDF, 16'h7FDF, 1'b1);
    wait_idle();
  endtask

  task automatic test_backpressure();
    bit stable = 1'b1;
    out_ready = 1'b0;
    send(16'h2C00, 16'd5500, 16'd5500, 1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 16'h1000;
    q0.push_back(16'h8000);
    q1.push_back(16'h8000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (!(out_valid0 && out_valid1 && !in_ready0 && !in_ready1 &&
            out_data0 === 16'd5500 && out_data1 === 16'd5500)) stable = 1'b0;
    end
    n_checks++;
    if (!stable) $display("FAIL bp_hold: vld=%b rdy=%b data=%0d, want 1 0 5500",
                          out_valid0, in_ready0, out_data0);
    else n_pass++;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid0, in_ready0} !== 2'b10)
      $display("FAIL bp_release: vld=%b rdy=%b, want 1 0", out_valid0, in_ready0);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({out_valid0, in_ready0, out_valid1, in_ready1} !== 4'b0101)
      $display("FAIL bp_idle: vld=%b rdy=%b, want 0 1", out_valid0, in_ready0);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cs0, addr0} !== {1'b1, 5'd2})
      $display("FAIL bp_next_accept: cs=%b addr=%0d, want 1 2", cs0, addr0);
    else n_pass++;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    bit ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 16'h2C00;
    q0.push_back(16'd5500);
    q1.push_back(16'd5500);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready0) ok = 1'b1;
    end
    @(posedge clk); #1;
    in_data = 16'h0400; // idx 0, frac 1024: 0 + 500
    q0.push_back(16'd500);
    q1.push_back(16'd500);
    ok = 1'b0;
    while (n < 20 && !ok) begin
      @(negedge clk);
      n++;
      if (in_ready0) ok = 1'b1;
    end
    n_checks++;
    if (n != 5) $display("FAIL b2b_spacing: got %0d cycles, want 5", n);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_midflight();
    bit quiet = 1'b1;
    send(16'h2C00, 16'd0, 16'd0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_ready0, cs0, out_valid0, in_ready1, cs1, out_valid1} !== 6'b100100)
      $display("FAIL rst_mid: rdy=%b cs=%b vld=%b, want 1 0 0", in_ready0, cs0, out_valid0);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid0 || out_valid1) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) $display("FAIL rst_discard: out_valid rose, want 0");
    else n_pass++;
    send(16'h2C00, 16'd5500, 16'd5500, 1'b1);
    wait_idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) tbl[i] = {16'hABCD, 16'(i * 1000)};
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_extremes();
    test_backpressure();
    test_reset_midflight();
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0)
      $display("FAIL sb_drain: %0d/%0d results outstanding, want 0/0", q0.size(), q1.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1);
  end

endmodule
